// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM sequencer: controller state type and the
// default widths of the size inputs, loop counters and SRAM address buses.
package gemm_pkg;

    localparam int unsigned GemmAddrWidth      = 12;
    localparam int unsigned GemmSramAddrWidthA = 12;
    localparam int unsigned GemmSramAddrWidthB = 12;
    localparam int unsigned GemmSramAddrWidthC = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } gemm_ctrl_state_e;

endpackage

// File: rtl/gemm_loop_counter.sv
// One level of the m/n/k loop nest.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   clear_i        return the count to zero (wins over enable_i)
//   enable_i       advance the count by one
//   bound_i        last valid count value (loop size minus one)
//   count_o        current count
//   last_o         count_o equals bound_i
module gemm_loop_counter #(
    parameter int unsigned Width = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [Width-1:0] bound_i,
    output logic [Width-1:0] count_o,
    output logic             last_o
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] count_r;

    // Loop index register; clear has priority over enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= {Width{1'b0}};
        end else if (clear_i) begin
            count_r <= {Width{1'b0}};
        end else if (enable_i) begin
            count_r <= count_r + One;
        end
    end

    assign count_o = count_r;
    assign last_o  = (count_r == bound_i);

endmodule

// File: rtl/gemm_controller.sv
// Sequencer for the output-stationary GEMM accelerator. Latches M/K/N on an
// accepted start, walks m (outer), n, k (inner) and produces row-major SRAM
// addresses with incremental adders only, plus the MAC and C-write strobes.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i                    start request, only looked at in IDLE
//   M_size_i/K_size_i/N_size_i matrix sizes, latched at start
//   sram_a_addr_o              A read address  m*K+k   (COMPUTE only)
//   sram_b_addr_o              B read address  k*N+n   (COMPUTE only)
//   sram_c_addr_o              C address       m*N+n   (COMPUTE and WRITE)
//   sram_c_we_o                C write strobe (WRITE)
//   mac_en_o, mac_clear_o      accumulate / load-first-product strobes
//   busy_o                     run in progress, through the DONE cycle
//   done_o                     one-cycle completion pulse
module gemm_controller
    import gemm_pkg::*;
#(
    parameter int unsigned AddrWidth      = GemmAddrWidth,
    parameter int unsigned SRAMAddrWidthA = GemmSramAddrWidthA,
    parameter int unsigned SRAMAddrWidthB = GemmSramAddrWidthB,
    parameter int unsigned SRAMAddrWidthC = GemmSramAddrWidthC
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [AddrWidth-1:0]      M_size_i,
    input  logic [AddrWidth-1:0]      K_size_i,
    input  logic [AddrWidth-1:0]      N_size_i,
    output logic [SRAMAddrWidthA-1:0] sram_a_addr_o,
    output logic [SRAMAddrWidthB-1:0] sram_b_addr_o,
    output logic [SRAMAddrWidthC-1:0] sram_c_addr_o,
    output logic                      sram_c_we_o,
    output logic                      mac_en_o,
    output logic                      mac_clear_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam logic [AddrWidth-1:0]      OneW = {{(AddrWidth-1){1'b0}}, 1'b1};
    localparam logic [SRAMAddrWidthA-1:0] OneA = {{(SRAMAddrWidthA-1){1'b0}}, 1'b1};
    localparam logic [SRAMAddrWidthB-1:0] OneB = {{(SRAMAddrWidthB-1){1'b0}}, 1'b1};
    localparam logic [SRAMAddrWidthC-1:0] OneC = {{(SRAMAddrWidthC-1){1'b0}}, 1'b1};

    gemm_ctrl_state_e state_r, state_next_s;

    logic [AddrWidth-1:0]      m_size_r, k_size_r, n_size_r;
    logic [AddrWidth-1:0]      m_bound_s, k_bound_s, n_bound_s;
    logic [AddrWidth-1:0]      m_count_s, k_count_s, n_count_s;
    logic                      m_last_s, k_last_s, n_last_s;
    logic [SRAMAddrWidthA-1:0] a_addr_r, a_base_r, a_step_s;
    logic [SRAMAddrWidthB-1:0] b_addr_r, b_step_s;
    logic [SRAMAddrWidthC-1:0] c_addr_r;
    logic                      accept_s, in_compute_s, in_write_s, run_last_s;
    logic                      any_zero_s;

    assign accept_s     = (state_r == IDLE) && start_i;
    assign in_compute_s = (state_r == COMPUTE);
    assign in_write_s   = (state_r == WRITE);
    assign any_zero_s   = (M_size_i == {AddrWidth{1'b0}}) || (K_size_i == {AddrWidth{1'b0}})
                          || (N_size_i == {AddrWidth{1'b0}});

    assign m_bound_s = m_size_r - OneW;
    assign k_bound_s = k_size_r - OneW;
    assign n_bound_s = n_size_r - OneW;

    // Row stride of A (moving to the next m) and of B (moving to the next k)
    assign a_step_s = SRAMAddrWidthA'(k_size_r);
    assign b_step_s = SRAMAddrWidthB'(n_size_r);

    // The whole run ends after the WRITE of the final (m,n) element
    assign run_last_s = (m_count_s == m_bound_s) && n_last_s;

    gemm_loop_counter #(.Width(AddrWidth)) u_k_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (accept_s || in_write_s),
        .enable_i (in_compute_s && !k_last_s),
        .bound_i  (k_bound_s),
        .count_o  (k_count_s),
        .last_o   (k_last_s)
    );

    gemm_loop_counter #(.Width(AddrWidth)) u_n_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (accept_s || (in_write_s && n_last_s)),
        .enable_i (in_write_s && !n_last_s),
        .bound_i  (n_bound_s),
        .count_o  (n_count_s),
        .last_o   (n_last_s)
    );

    gemm_loop_counter #(.Width(AddrWidth)) u_m_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (accept_s),
        .enable_i (in_write_s && n_last_s && !m_last_s),
        .bound_i  (m_bound_s),
        .count_o  (m_count_s),
        .last_o   (m_last_s)
    );

    // Controller state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = any_zero_s ? DONE : COMPUTE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMPUTE: begin
                if (k_last_s) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = COMPUTE;
                end
            end
            WRITE: begin
                if (run_last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = COMPUTE;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Size latches and incremental address registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size_r <= {AddrWidth{1'b0}};
            k_size_r <= {AddrWidth{1'b0}};
            n_size_r <= {AddrWidth{1'b0}};
            a_addr_r <= {SRAMAddrWidthA{1'b0}};
            a_base_r <= {SRAMAddrWidthA{1'b0}};
            b_addr_r <= {SRAMAddrWidthB{1'b0}};
            c_addr_r <= {SRAMAddrWidthC{1'b0}};
        end else if (accept_s) begin
            m_size_r <= M_size_i;
            k_size_r <= K_size_i;
            n_size_r <= N_size_i;
            a_addr_r <= {SRAMAddrWidthA{1'b0}};
            a_base_r <= {SRAMAddrWidthA{1'b0}};
            b_addr_r <= {SRAMAddrWidthB{1'b0}};
            c_addr_r <= {SRAMAddrWidthC{1'b0}};
        end else if (in_compute_s && !k_last_s) begin
            a_addr_r <= a_addr_r + OneA;
            b_addr_r <= b_addr_r + b_step_s;
        end else if (in_write_s && !run_last_s) begin
            c_addr_r <= c_addr_r + OneC;
            if (n_last_s) begin
                // Next row of C: A restarts one row further down, B at column 0
                a_base_r <= a_base_r + a_step_s;
                a_addr_r <= a_base_r + a_step_s;
                b_addr_r <= {SRAMAddrWidthB{1'b0}};
            end else begin
                // Next column of C: same A row, B column n+1
                a_addr_r <= a_base_r;
                b_addr_r <= SRAMAddrWidthB'(n_count_s) + OneB;
            end
        end
    end

    // Output decode from registered state and address registers
    always_comb begin
        sram_a_addr_o = {SRAMAddrWidthA{1'b0}};
        sram_b_addr_o = {SRAMAddrWidthB{1'b0}};
        sram_c_addr_o = {SRAMAddrWidthC{1'b0}};
        sram_c_we_o   = 1'b0;
        mac_en_o      = 1'b0;
        mac_clear_o   = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (state_r)
            IDLE: begin
                busy_o = 1'b0;
            end
            COMPUTE: begin
                busy_o        = 1'b1;
                mac_en_o      = 1'b1;
                mac_clear_o   = (k_count_s == {AddrWidth{1'b0}});
                sram_a_addr_o = a_addr_r;
                sram_b_addr_o = b_addr_r;
                sram_c_addr_o = c_addr_r;
            end
            WRITE: begin
                busy_o        = 1'b1;
                sram_c_we_o   = 1'b1;
                sram_c_addr_o = c_addr_r;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gemm_controller.sv
// Directed bench for gemm_controller: per-cycle sequence checks against a
// loop-nest reference, hand-written address tables, a MAC/SRAM model for a
// full 32x32x32 product, start-while-busy, back-to-back and reset cases.
module tb_gemm_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [11:0] M_size_i, K_size_i, N_size_i;
    logic [11:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
    logic        sram_c_we_o, mac_en_o, mac_clear_o, busy_o, done_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  amem [4096];
    logic [7:0]  bmem [4096];
    logic [31:0] cmem [4096];
    logic [31:0] acc;
    int          a_log[$];
    int          b_log[$];
    int          c_log[$];

    gemm_controller dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .M_size_i      (M_size_i),
        .K_size_i      (K_size_i),
        .N_size_i      (N_size_i),
        .sram_a_addr_o (sram_a_addr_o),
        .sram_b_addr_o (sram_b_addr_o),
        .sram_c_addr_o (sram_c_addr_o),
        .sram_c_we_o   (sram_c_we_o),
        .mac_en_o      (mac_en_o),
        .mac_clear_o   (mac_clear_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic pulse_start(input int m, input int k, input int n);
        @(negedge clk_i);
        M_size_i = 12'(m);
        K_size_i = 12'(k);
        N_size_i = 12'(n);
        start_i  = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Start a run and follow it cycle by cycle against the m/n/k loop nest.
    // With poke set, start_i is raised mid-run with other sizes for one cycle.
    task automatic walk_run(input string name, input int m, input int k, input int n,
                            input int exp_total, input bit poke);
        int          cyc;
        logic [40:0] obs;
        logic [40:0] exp;
        a_log.delete();
        b_log.delete();
        c_log.delete();
        pulse_start(m, k, n);
        cyc = 0;
        if (m != 0 && k != 0 && n != 0) begin
            for (int mi = 0; mi < m; mi++) begin
                for (int ni = 0; ni < n; ni++) begin
                    for (int ki = 0; ki < k; ki++) begin
                        @(negedge clk_i);
                        cyc++;
                        obs = {busy_o, done_o, sram_c_we_o, mac_en_o, mac_clear_o,
                               sram_a_addr_o, sram_b_addr_o, 12'd0};
                        exp = {1'b1, 1'b0, 1'b0, 1'b1, (ki == 0),
                               12'(mi * k + ki), 12'(ki * n + ni), 12'd0};
                        n_cmp++;
                        if (obs !== exp) begin
                            n_fail++;
                            $display("FAIL %s compute cyc=%0d got=%h want=%h", name, cyc, obs, exp);
                        end
                        a_log.push_back(int'(sram_a_addr_o));
                        b_log.push_back(int'(sram_b_addr_o));
                        if (mac_clear_o)
                            acc = 32'(amem[sram_a_addr_o]) * 32'(bmem[sram_b_addr_o]);
                        else
                            acc = acc + 32'(amem[sram_a_addr_o]) * 32'(bmem[sram_b_addr_o]);
                        if (poke && cyc == 5) begin
                            start_i  = 1'b1;
                            M_size_i = 12'd3;
                            K_size_i = 12'd3;
                            N_size_i = 12'd3;
                        end else if (poke && cyc == 6) begin
                            start_i = 1'b0;
                        end
                    end
                    @(negedge clk_i);
                    cyc++;
                    obs = {busy_o, done_o, sram_c_we_o, mac_en_o, mac_clear_o,
                           24'd0, sram_c_addr_o};
                    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 12'(mi * n + ni)};
                    n_cmp++;
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL %s write cyc=%0d got=%h want=%h", name, cyc, obs, exp);
                    end
                    c_log.push_back(int'(sram_c_addr_o));
                    cmem[sram_c_addr_o] = acc;
                end
            end
        end
        @(negedge clk_i);
        cyc++;
        obs = {busy_o, done_o, sram_c_we_o, mac_en_o, mac_clear_o,
               sram_a_addr_o, sram_b_addr_o, sram_c_addr_o};
        n_cmp++;
        if (obs !== {1'b1, 1'b1, 39'd0}) begin
            n_fail++;
            $display("FAIL %s done_cycle got=%h want=%h", name, obs, {1'b1, 1'b1, 39'd0});
        end
        n_cmp++;
        if (cyc != exp_total) begin
            n_fail++;
            $display("FAIL %s latency got=%0d want=%0d", name, cyc, exp_total);
        end
        repeat (poke ? 8 : 1) begin
            @(negedge clk_i);
            obs = {busy_o, done_o, sram_c_we_o, mac_en_o, mac_clear_o,
                   sram_a_addr_o, sram_b_addr_o, sram_c_addr_o};
            n_cmp++;
            if (obs !== 41'd0) begin
                n_fail++;
                $display("FAIL %s idle_after got=%h want=0", name, obs);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        M_size_i = 12'd0;
        K_size_i = 12'd0;
        N_size_i = 12'd0;
        #12;
        n_cmp++;
        if ({busy_o, done_o, sram_c_we_o, mac_en_o, mac_clear_o,
             sram_a_addr_o, sram_b_addr_o, sram_c_addr_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b done=%b we=%b en=%b want all 0",
                     busy_o, done_o, sram_c_we_o, mac_en_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_unit();
        walk_run("unit_1x1x1", 1, 1, 1, 3, 1'b0);
    endtask

    task automatic test_small();
        int a_tbl[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
        int b_tbl[12] = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
        walk_run("small_2x3x2", 2, 3, 2, 17, 1'b0);
        n_cmp++;
        if (a_log.size() != 12 || c_log.size() != 4) begin
            n_fail++;
            $display("FAIL small_counts a=%0d c=%0d want 12/4", a_log.size(), c_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_cmp++;
                if (a_log[i] != a_tbl[i] || b_log[i] != b_tbl[i]) begin
                    n_fail++;
                    $display("FAIL small_ab[%0d] got=%0d/%0d want=%0d/%0d",
                             i, a_log[i], b_log[i], a_tbl[i], b_tbl[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (c_log[i] != i) begin
                    n_fail++;
                    $display("FAIL small_c[%0d] got=%0d want=%0d", i, c_log[i], i);
                end
            end
        end
    endtask

    task automatic test_zero_k();
        walk_run("zero_k_4x0x4", 4, 0, 4, 1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        walk_run("busy_start_2x3x2", 2, 3, 2, 17, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] tbl [8] = '{4'b1001, 4'b1010, 4'b1100, 4'b0000,
                                4'b1001, 4'b1010, 4'b1100, 4'b0000};
        @(negedge clk_i);
        M_size_i = 12'd1;
        K_size_i = 12'd1;
        N_size_i = 12'd1;
        start_i  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, done_o, sram_c_we_o, mac_en_o} !== tbl[i]) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got=%b want=%b", i,
                         {busy_o, done_o, sram_c_we_o, mac_en_o}, tbl[i]);
            end
            if (i == 6) start_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(4, 4, 4);
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (mac_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_precond mac_en got=%b want=1", mac_en_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, sram_c_we_o, mac_en_o, mac_clear_o,
             sram_a_addr_o, sram_b_addr_o, sram_c_addr_o} !== 41'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async busy=%b en=%b a=%0d b=%0d want all 0",
                     busy_o, mac_en_o, sram_a_addr_o, sram_b_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            n_cmp++;
            if ({busy_o, done_o, sram_c_we_o, mac_en_o} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rst_mid_quiet got=%b want=0000",
                         {busy_o, done_o, sram_c_we_o, mac_en_o});
            end
        end
        walk_run("after_reset_1x1x1", 1, 1, 1, 3, 1'b0);
    endtask

    task automatic test_gemm32();
        logic [31:0] sum;
        for (int i = 0; i < 1024; i++) begin
            amem[i] = 8'($urandom_range(0, 255));
            bmem[i] = 8'($urandom_range(0, 255));
            cmem[i] = 32'hDEADBEEF;
        end
        walk_run("gemm_32", 32, 32, 32, 33793, 1'b0);
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                sum = 32'd0;
                for (int kk = 0; kk < 32; kk++)
                    sum = sum + 32'(amem[i * 32 + kk]) * 32'(bmem[kk * 32 + j]);
                n_cmp++;
                if (cmem[i * 32 + j] !== sum) begin
                    n_fail++;
                    $display("FAIL gemm_c[%0d][%0d] got=%0d want=%0d", i, j, cmem[i * 32 + j], sum);
                end
            end
        end
    endtask

    initial begin
        acc = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            amem[i] = 8'd0;
            bmem[i] = 8'd0;
            cmem[i] = 32'd0;
        end
        test_reset();
        test_unit();
        test_small();
        test_zero_k();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_gemm32();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_controller.md
# gemm_controller

Sequencer for the output-stationary GEMM accelerator. It latches the matrix sizes on `start_i`, walks the m/n/k loop nest and generates row-major SRAM addresses for A (M×K), B (K×N) and C (M×N). It drives the clear/enable strobes of the single MAC datapath and the C write strobe, then pulses `done_o`. It sits inside `gemm_accelerator_top`, between the top-level ports and the MAC datapath.

## Interface
- `AddrWidth`, 12, width of the size inputs and loop counters.
- `SRAMAddrWidthA`, 12, A address width.
- `SRAMAddrWidthB`, 12, B address width.
- `SRAMAddrWidthC`, 12, C address width.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request, sampled only in IDLE.
- `M_size_i`, `K_size_i`, `N_size_i` in AddrWidth each: matrix sizes, unsigned.
- `sram_a_addr_o` out SRAMAddrWidthA: A read address, m*K+k.
- `sram_b_addr_o` out SRAMAddrWidthB: B read address, k*N+n.
- `sram_c_addr_o` out SRAMAddrWidthC: C write address, m*N+n.
- `sram_c_we_o` out 1: C write strobe.
- `mac_en_o` out 1: datapath accumulates this cycle.
- `mac_clear_o` out 1: with `mac_en_o`, load the product instead of accumulating (k==0).
- `busy_o` out 1: high from the cycle after accepted start through the DONE cycle.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, COMPUTE, WRITE, DONE. The state encoding and reset state are IDLE.
- **IDLE:** on `start_i`=1, latch M, K and N and zero all counters.
  - If any size is 0, go to DONE.
  - Otherwise go to COMPUTE.
- **COMPUTE:** one k step per cycle.
  - `mac_en_o`=1; `mac_clear_o`=(k==0).
  - Address outputs show the current (m,n,k).
  - If k==K-1, go to WRITE. Otherwise k++, a_addr+=1, b_addr+=N.
- **WRITE:** `sram_c_we_o`=1 with `sram_c_addr_o`=c_addr. The datapath accumulator holds the finished sum.
  - If m==M-1 and n==N-1, go to DONE.
  - Otherwise c_addr++ and k=0.
    - If n==N-1: n=0, m++, a_base+=K, b_addr=0.
    - Else: n++, b_addr=n+1.
    - a_addr=a_base.
  - Then go to COMPUTE.
- **DONE:** `done_o`=1 for exactly one cycle, then IDLE.
- Address arithmetic is incremental adders only, with no multipliers. All address arithmetic wraps modulo 2^SRAMAddrWidthX.
- The caller guarantees M*K, K*N and M*N fit the SRAM depths. There is no internal bounds check.
- Sizes are held in registers for the whole run. Changes on `M_size_i`, `K_size_i` or `N_size_i` while busy have no effect.
- `start_i` while busy (COMPUTE, WRITE or DONE) is ignored. It is not queued.

## Timing
- All outputs are registered or decoded from registered state and counters. There is no combinational path from the inputs to the outputs.
- **Reset:** all outputs are 0, and the state is IDLE. An asserted reset mid-run aborts immediately. No further C writes occur, and `done_o` is not pulsed.
- A/B reads are combinational. Data for the address presented in cycle t is consumed by the MAC at the edge ending cycle t.
- **First cycle:** start is accepted at edge t0. The first COMPUTE cycle (k=0, addresses 0/0) follows immediately after t0.
- Each output element takes K COMPUTE cycles plus 1 WRITE cycle.
- `done_o` is high in the cycle M*N*(K+1) after the first COMPUTE cycle. Total from accept to `done_o`: M*N*(K+1)+1 cycles.
- Zero-size run: `done_o` is high in the cycle after the start edge, with no writes.
- In IDLE and DONE, the address outputs are 0 and all strobes are 0 except `done_o` in DONE.
- Back-to-back runs: `start_i` is accepted again in the cycle after DONE (IDLE). A `start_i` held high continuously restarts immediately.

## Structure
- `gemm_pkg` holds the shared items:
  - `gemm_ctrl_state_e` (IDLE/COMPUTE/WRITE/DONE).
  - The default width localparams (12).
- Sub-module `gemm_loop_counter` is instantiated three times for k, n and m:
  - Parameterized width.
  - Inputs: clear, enable, and the bound (size-1).
  - Outputs: count and `last_o` (count==bound).

## Test plan
- **M=K=N=1:** start → one COMPUTE (a=0, b=0, clear=1), then WRITE c=0, then `done_o` 2 cycles after the first COMPUTE; `busy_o` is high 3 cycles.
- **M=2, K=3, N=2:**
  - A sequence is 0,1,2, 0,1,2, 3,4,5, 3,4,5.
  - B sequence is 0,2,4, 1,3,5, 0,2,4, 1,3,5.
  - C writes go to 0,1,2,3.
  - `done_o` is at cycle 16 after the first COMPUTE.
- **K=0 (M=N=4):** `done_o` one cycle after start, and `sram_c_we_o` is never asserted.
- **Start while busy:** pulse `start_i` mid-run with different sizes → no restart, the original address sequence completes, and exactly one `done_o`.
- **Reset mid-run:** drop `rst_ni` during COMPUTE of a 4×4×4 run → all outputs are 0 asynchronously. After release, a new start with 1×1×1 behaves as in the first scenario.
- **32×32×32 random data with a MAC model:** C matches the golden GEMM, and start-to-done is 33793 cycles.
